// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and the RGB332 pixel type
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE_LAT = 1;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  function automatic logic [11:0] expand332(input rgb332_t p);
    return {p.r, p.r[2], p.g, p.g[2], p.b, p.b};
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register delay with a reset value; DEPTH=0 is a wire
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk or negedge resetN)
      if (!resetN) sr <= {DEPTH{RESET_VAL}};
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_output.sv
// vga_timing_output: raster counters plus pipeline-aligned sync, blank and RGB444 pins
module vga_timing_output #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP,
  parameter int PIPE_LAT = vga_timing_pkg::PIPE_LAT
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [7:0]         RGBIn,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               startOfFrame,
  output logic               hsyncN,
  output logic               vsyncN,
  output logic               blankN,
  output logic [3:0]         vgaR,
  output logic [3:0]         vgaG,
  output logic [3:0]         vgaB
);
  import vga_timing_pkg::rgb332_t, vga_timing_pkg::expand332;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  logic [10:0] h_count, v_count;
  logic h_wrap, v_wrap, hs_raw, vs_raw, vis_raw, hs_d, vs_d, vis_d;
  assign h_wrap = h_count == 11'(H_TOTAL - 1);
  assign v_wrap = v_count == 11'(V_TOTAL - 1);
  assign hs_raw = !(h_count >= 11'(HS_START) && h_count < 11'(HS_START + H_SYNC));
  assign vs_raw = !(v_count >= 11'(VS_START) && v_count < 11'(VS_START + V_SYNC));
  assign vis_raw = h_count < 11'(H_ACTIVE) && v_count < 11'(V_ACTIVE);
  assign pixelX = $signed(h_count);
  assign pixelY = $signed(v_count);
  // Matches the mux's register stage so sync/blank meet RGBIn for the same pixel
  vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT), .RESET_VAL(3'b110)) u_delay (
    .clk(clk),
    .resetN(resetN),
    .d({hs_raw, vs_raw, vis_raw}),
    .q({hs_d, vs_d, vis_d})
  );
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      h_count <= '0;
      v_count <= '0;
      startOfFrame <= 1'b0;
      hsyncN <= 1'b1;
      vsyncN <= 1'b1;
      blankN <= 1'b0;
      {vgaR, vgaG, vgaB} <= '0;
    end else begin
      h_count <= h_wrap ? '0 : h_count + 11'd1;
      if (h_wrap) v_count <= v_wrap ? '0 : v_count + 11'd1;
      // Registered so the pulse coincides with pixelX=0, pixelY=V_ACTIVE
      startOfFrame <= h_wrap && v_count == 11'(V_ACTIVE - 1);
      hsyncN <= hs_d;
      vsyncN <= vs_d;
      blankN <= vis_d;
      {vgaR, vgaG, vgaB} <= vis_d ? expand332(rgb332_t'(RGBIn)) : 12'h000;
    end
endmodule

// File: tb/tb_vga_timing_output.sv
// tb_vga_timing_output: randomized checks of counters, sync, blanking and colour against a position model
module tb_vga_timing_output;
  localparam int HT = 800, HA = 640, HS0 = 656, HSW = 96;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB, FR = HT * VT, LAT = 1;
  logic clk = 0, resetN = 0;
  logic [7:0] RGBIn = 8'h00;
  logic signed [10:0] pixelX, pixelY;
  logic startOfFrame, hsyncN, vsyncN, blankN;
  logic [3:0] vgaR, vgaG, vgaB;
  int vectors = 0, errors = 0, cyc = 0, mode = 0;
  logic [7:0] pix_mem [HT];
  logic [7:0] drv [65536];

  vga_timing_output #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_LAT(LAT)) dut (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .hsyncN(hsyncN), .vsyncN(vsyncN), .blankN(blankN),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge resetN)
    if (!resetN) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] mux_f(int c);
    int x = c % HT;
    if (mode == 1) return 8'hFF;
    if (mode == 2) return x == 10 ? 8'hE0 : x == 11 ? 8'h1C : x == 12 ? 8'h03 : x == 20 ? 8'h92 : 8'h00;
    return pix_mem[x];
  endfunction

  function automatic logic [21:0] exp_pos(int c);
    return {11'(c % HT), 11'((c / HT) % VT)};
  endfunction

  function automatic logic [14:0] exp_pins(int c);
    int p, x, y;
    logic vis;
    logic [7:0] v;
    if (c < LAT + 1) return {3'b110, 12'h000};
    p = c - LAT - 1;
    x = p % HT;
    y = (p / HT) % VT;
    vis = x < HA && y < VA;
    v = drv[(c - 1) & 16'hFFFF];
    return {!(x >= HS0 && x < HS0 + HSW), !(y >= VA + VF && y < VA + VF + VS), vis,
            vis ? {4'(v[7:5] * 2 + v[7:5] / 4), 4'(v[4:2] * 2 + v[4:2] / 4), 4'(v[1:0] * 5)} : 12'h000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1 RGBIn = mux_f(cyc - 1);
    drv[cyc & 16'hFFFF] = RGBIn;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetN = 1;
    drv[0] = RGBIn;
  endtask

  task automatic test_reset();
    RGBIn = 8'hFF;
    mode = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pixelX, pixelY, startOfFrame, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== {22'd0, 4'b0110, 12'h000}) begin
      errors++;
      $display("FAIL reset_hold: got x=%0d y=%0d sof=%b hs=%b vs=%b bl=%b rgb=%h%h%h", pixelX, pixelY,
               startOfFrame, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB);
    end
    release_reset();
    vectors++;
    if ({pixelX, pixelY} !== 22'd0) begin
      errors++;
      $display("FAIL reset_release_pos: got x=%0d y=%0d want 0,0", pixelX, pixelY);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== exp_pins(cyc)) begin
        errors++;
        $display("FAIL reset_pins cyc=%0d: got %h want %h", cyc, {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB}, exp_pins(cyc));
      end
      if (cyc == LAT + 1) begin
        vectors++;
        if ({blankN, vgaR, vgaG, vgaB} !== 13'h1FFF) begin
          errors++;
          $display("FAIL first_visible: got bl=%b rgb=%h%h%h want 1 FFF", blankN, vgaR, vgaG, vgaB);
        end
      end
    end
  endtask

  task automatic test_line();
    int fall = -1, run = 0, low_len = -1, blank_cnt = 0;
    logic prev_hs = 1;
    mode = 0;
    foreach (pix_mem[i]) pix_mem[i] = 8'($urandom);
    while (cyc < 3 * HT) begin
      step();
      vectors++;
      if ({pixelX, pixelY} !== exp_pos(cyc) || {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== exp_pins(cyc)) begin
        errors++;
        $display("FAIL line cyc=%0d: got x=%0d y=%0d pins=%h want pos=%h pins=%h", cyc, pixelX, pixelY,
                 {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB}, exp_pos(cyc), exp_pins(cyc));
      end
      if (prev_hs && !hsyncN) begin
        fall = cyc;
        run = 0;
      end
      if (!hsyncN) run++;
      if (!prev_hs && hsyncN) low_len = run;
      if (cyc >= HT + LAT + 1 && cyc < 2 * HT + LAT + 1 && blankN) blank_cnt++;
      prev_hs = hsyncN;
    end
    vectors++;
    if (fall % HT != HS0 + LAT + 1) begin
      errors++;
      $display("FAIL hsync_fall: got offset %0d want %0d", fall % HT, HS0 + LAT + 1);
    end
    vectors++;
    if (low_len != HSW) begin
      errors++;
      $display("FAIL hsync_width: got %0d want %0d", low_len, HSW);
    end
    vectors++;
    if (blank_cnt != HA) begin
      errors++;
      $display("FAIL blank_per_line: got %0d want %0d", blank_cnt, HA);
    end
  endtask

  task automatic test_colour();
    logic [11:0] want;
    mode = 2;
    while (cyc < 4 * HT) begin
      step();
      vectors++;
      if ({hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== exp_pins(cyc)) begin
        errors++;
        $display("FAIL colour_pins cyc=%0d: got %h want %h", cyc, {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB}, exp_pins(cyc));
      end
      if (cyc / HT == 3 && (cyc % HT inside {[11:15], 22})) begin
        case (cyc % HT)
          12: want = 12'hF00;
          13: want = 12'h0F0;
          14: want = 12'h00F;
          22: want = 12'h99A;
          default: want = 12'h000;
        endcase
        vectors++;
        if ({vgaR, vgaG, vgaB} !== want) begin
          errors++;
          $display("FAIL colour_x%0d: got %h%h%h want %h", cyc % HT - LAT - 1, vgaR, vgaG, vgaB, want);
        end
      end
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, sofs = 0, last_sof = -1;
    mode = 1;
    while (cyc < 2 * FR) begin
      step();
      vectors++;
      if ({pixelX, pixelY, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== {exp_pos(cyc), exp_pins(cyc)}) begin
        errors++;
        $display("FAIL frame cyc=%0d: got x=%0d y=%0d pins=%h want pins=%h", cyc, pixelX, pixelY,
                 {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB}, exp_pins(cyc));
      end
      vectors++;
      if ({vgaR, vgaG, vgaB} !== (blankN ? 12'hFFF : 12'h000)) begin
        errors++;
        $display("FAIL blanking cyc=%0d: got bl=%b rgb=%h%h%h", cyc, blankN, vgaR, vgaG, vgaB);
      end
      if (cyc < FR + LAT + 1 && !vsyncN) vs_low++;
      if (startOfFrame) begin
        sofs++;
        vectors++;
        if (pixelX !== 11'sd0 || pixelY !== 11'(VA) || (last_sof >= 0 && cyc - last_sof != FR)) begin
          errors++;
          $display("FAIL sof_place: got x=%0d y=%0d gap=%0d want 0,%0d gap %0d", pixelX, pixelY, cyc - last_sof, VA, FR);
        end
        last_sof = cyc;
      end
    end
    vectors++;
    if (vs_low != VS * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d want %0d", vs_low, VS * HT);
    end
    vectors++;
    if (sofs != 2) begin
      errors++;
      $display("FAIL sof_count: got %0d want 2", sofs);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mode = 0;
    foreach (pix_mem[i]) pix_mem[i] = 8'($urandom);
    while (!(pixelY == 11'sd3 && pixelX == 11'sd300) && n < FR) begin
      step();
      n++;
    end
    vectors++;
    if (n >= FR) begin
      errors++;
      $display("FAIL mid_reset_reach: position 300,3 not reached, x=%0d y=%0d", pixelX, pixelY);
    end
    #2 resetN = 0;
    #1;
    vectors++;
    if ({pixelX, pixelY, startOfFrame, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== {22'd0, 4'b0110, 12'h000}) begin
      errors++;
      $display("FAIL mid_reset_async: got x=%0d y=%0d sof=%b hs=%b vs=%b bl=%b rgb=%h%h%h", pixelX, pixelY,
               startOfFrame, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB);
    end
    repeat (2) @(negedge clk);
    release_reset();
    n = 0;
    while (!startOfFrame && n < VA * HT + 10) begin
      step();
      n++;
      vectors++;
      if ({pixelX, pixelY, hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB} !== {exp_pos(cyc), exp_pins(cyc)}) begin
        errors++;
        $display("FAIL restart cyc=%0d: got x=%0d y=%0d pins=%h want pins=%h", cyc, pixelX, pixelY,
                 {hsyncN, vsyncN, blankN, vgaR, vgaG, vgaB}, exp_pins(cyc));
      end
    end
    vectors++;
    if (!startOfFrame || n != VA * HT) begin
      errors++;
      $display("FAIL restart_sof: got sof=%b after %0d clocks want 1 after %0d", startOfFrame, n, VA * HT);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_colour();
    test_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_output.md
Name: vga_timing_output

Overview:
Display-side consumer of the object mux output. Generates the 640x480@60 raster counters (pixelX/pixelY) that drive every drawing object and the mux. Registers the mux's 8-bit RGB332 pixel, expands it to 4:4:4 for the VGA DAC, blanks it outside the active area, and delays hsync/vsync/blank so they line up with the pixel pipeline. Also emits a once-per-frame tick that game logic uses for its updates.

Parameters:
H_ACTIVE 640 visible pixels per line
H_FP 16 horizontal front porch, clocks
H_SYNC 96 horizontal sync width, clocks
H_BP 48 horizontal back porch, clocks
V_ACTIVE 480 visible lines
V_FP 10 vertical front porch, lines
V_SYNC 2 vertical sync width, lines
V_BP 33 vertical back porch, lines
PIPE_LAT 1 clocks from pixelX/pixelY to the matching RGBIn; the mux registers once, so 1

Ports:
clk in 1 pixel clock, 25.175 MHz
resetN in 1 asynchronous, active-low reset
RGBIn in 8 mux output, RGB332: R=[7:5], G=[4:2], B=[1:0]
pixelX out 11 signed, horizontal counter 0..H_TOTAL-1
pixelY out 11 signed, vertical counter 0..V_TOTAL-1
startOfFrame out 1 one-clock pulse per frame
hsyncN out 1 horizontal sync, active low, pipeline-aligned
vsyncN out 1 vertical sync, active low, pipeline-aligned
blankN out 1 high when the pin-level pixel is visible
vgaR out 4 red to DAC
vgaG out 4 green to DAC
vgaB out 4 blue to DAC

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCount increments every clock and wraps H_TOTAL-1 -> 0. vCount increments on the hCount wrap and wraps V_TOTAL-1 -> 0 on the same clock as the hCount wrap. pixelX = hCount and pixelY = vCount, both registered. There is no clamping; drawing objects decode the ranges themselves.
- Raw timing is combinational on the counters:
  - hs_raw low for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_raw low for vCount in [490, 491].
  - vis_raw = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
- Alignment:
  - hs_raw, vs_raw and vis_raw pass through a PIPE_LAT-deep delay line, then one output register. Total delay is PIPE_LAT+1 clocks.
  - RGBIn is sampled into the output register on the same clock as the delayed vis.
  - Net effect: pins show the pixel for counter (x,y) exactly PIPE_LAT+1 clocks after pixelX/pixelY = (x,y).
- Colour expansion, applied in the output register:
  - vgaR = {R[2:0], R[2]}
  - vgaG = {G[2:0], G[2]}
  - vgaB = {B[1:0], B[1:0]}
  - When delayed vis = 0, all three are forced to 0.
- blankN = registered delayed vis.
- startOfFrame: registered pulse, high for exactly one clock when hCount==0 && vCount==V_ACTIVE (start of vertical blank). Period is H_TOTAL*V_TOTAL = 420000 clocks.
- Reset, asynchronous, taking effect immediately even mid-frame:
  - Counters = 0, pixelX = pixelY = 0.
  - hsyncN = vsyncN = 1, blankN = 0, vgaR/G/B = 0, startOfFrame = 0.
  - Every delay-line stage holds the inactive values (sync 1, vis 0).
  - After release, hCount = 0 on the first clock edge and the frame restarts at line 0. No sync glitch is produced in the first PIPE_LAT+1 clocks.
- PIPE_LAT = 0 is legal: the delay line becomes a wire and total delay is 1 clock.
- All arithmetic is on 11-bit unsigned counters. Comparisons use the derived constants; there is no signed wrap risk because the maximum count is 799 < 1024.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default 640x480 constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL);
  - the rgb332 struct typedef;
  - the function expand332 returning the 12-bit R/G/B.
  Drawing objects and the mux import the same constants.
- One sub-module, vga_delay_line:
  - parameters WIDTH and DEPTH, plus a RESET_VAL vector;
  - asynchronous resetN;
  - instantiated with WIDTH=3 for {hs, vs, vis}.

Test Plan:
1. Reset release with RGBIn=8'hFF -> first clock pixelX=0, pixelY=0. Outputs hold hsyncN=1, vsyncN=1, blankN=0, RGB=0 until PIPE_LAT+1 clocks, then blankN=1 and R=G=B=4'hF.
2. One full line -> hsyncN low for exactly 96 clocks. The falling edge comes 656+PIPE_LAT+1 clocks after pixelX=0. Line period is 800 clocks; blankN is high for 640 clocks per active line.
3. One full frame -> vsyncN low for 1600 clocks, covering lines 490-491 shifted by PIPE_LAT+1. startOfFrame pulses once, at pixelX=0, pixelY=480. Successive pulses are 420000 clocks apart.
4. Colour/alignment: bench mux model drives RGBIn = f(pixelX) with PIPE_LAT delay: 8'hE0 at x=10, 8'h1C at x=11, 8'h03 at x=12, 8'h00 elsewhere. Pins show (F,0,0), (0,F,0), (0,0,F) on three consecutive clocks, exactly PIPE_LAT+1 clocks after pixelX=10, and 0 on the neighbouring clocks. Also 8'h92 -> (9,9,A).
5. Blanking: RGBIn=8'hFF constant -> vgaR/G/B=0 whenever blankN=0, covering pixelX 640-799 and lines 480-524 with the pipeline shift applied. No colour appears on the clock either side of the active window.
6. Reset mid-frame: resetN low at pixelY=200, pixelX=300 -> outputs take reset values without waiting for a clock edge. After release the counters restart at 0,0 and the next startOfFrame arrives 480*800 clocks later.
